pcileech_com_tx_serializer: RTL and testbench

//  64->32 TX serializer: companion of the COM-core RX 32->64 packer, for the path from the
//  clk-domain TX FIFO toward the FT601/ETH core. Emits each 64-bit word as two dwords, [63:32]

---
 rtl/pcileech_com_pkg.sv | 16 +
 rtl/pcileech_com_tx_serializer.sv | 192 +++++++++++++++++++
 tb/tb_pcileech_com_tx_serializer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcileech_com_pkg.sv
// Shared definitions for the COM-core TX/RX dword path: resync marker value
// and the TX serializer state encoding.
package pcileech_com_pkg;

   // Marker dword; a pair of these lets the far-end packer realign its phase.
   localparam logic [31:0] COM_RESYNC_DWORD = 32'h66665555;

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      RS0,
      RS1
   } com_tx_ser_state_t;

endpackage

// File: rtl/pcileech_com_tx_serializer.sv
// 64->32 TX serializer. Each accepted 64-bit word leaves as two dwords,
// [63:32] first, so the far-end packer ({acc<<32}|dw) rebuilds it.
// Optional feature macro: COM_TX_RESYNC_EN. When defined, two-dword resync
// markers are inserted at 64-bit boundaries: one pair out of reset, one after
// IDLE_RESYNC_CYCLES idle cycles, and one per resync_req. When undefined the
// stream is pure data and resync_req is ignored.
module pcileech_com_tx_serializer
   import pcileech_com_pkg::*;
#(
   parameter int IDLE_RESYNC_CYCLES = 1024,
   parameter int STAT_W             = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [31:0]       m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic              resync_req,
   output logic              busy,
   output logic [STAT_W-1:0] stat_dwords
);

   com_tx_ser_state_t state_reg, state_next;
   logic [63:0]       hold_reg, hold_next;
   logic [31:0]       m_data_reg, m_data_next;
   logic              m_valid_reg, m_valid_next;
   logic [STAT_W-1:0] stat_reg;
   logic              resync_pending_reg, resync_pending_next;
   logic              rs_done;
   logic              accept;
   logic              handshake;

   // Upstream may only load at a word boundary and never while a marker pair
   // is owed, which keeps markers from ever splitting a data word.
   assign s_ready   = ~rst & ~resync_pending_reg &
                      ((state_reg == IDLE) | ((state_reg == LO) & m_ready));
   assign accept    = s_valid & s_ready;
   assign handshake = m_valid_reg & m_ready;

   assign m_data      = m_data_reg;
   assign m_valid     = m_valid_reg;
   assign stat_dwords = stat_reg;
   assign busy        = ~rst & ((state_reg != IDLE) | resync_pending_reg);

   // Next-state and next-output logic; outputs only move on a handshake or
   // from IDLE, so m_data/m_valid stay frozen while stalled.
   always_comb begin
      state_next   = state_reg;
      hold_next    = hold_reg;
      m_data_next  = m_data_reg;
      m_valid_next = m_valid_reg;
      rs_done      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               hold_next    = s_data;
               m_data_next  = s_data[63:32];
               m_valid_next = 1'b1;
               state_next   = HI;
            end else if (resync_pending_reg) begin
               m_data_next  = COM_RESYNC_DWORD;
               m_valid_next = 1'b1;
               state_next   = RS0;
            end else begin
               m_valid_next = 1'b0;
            end
         end
         HI: begin
            if (m_ready) begin
               m_data_next = hold_reg[31:0];
               state_next  = LO;
            end
         end
         LO: begin
            if (m_ready) begin
               if (accept) begin
                  hold_next    = s_data;
                  m_data_next  = s_data[63:32];
                  m_valid_next = 1'b1;
                  state_next   = HI;
               end else if (resync_pending_reg) begin
                  m_data_next  = COM_RESYNC_DWORD;
                  m_valid_next = 1'b1;
                  state_next   = RS0;
               end else begin
                  m_valid_next = 1'b0;
                  state_next   = IDLE;
               end
            end
         end
         RS0: begin
            if (m_ready) begin
               state_next = RS1;
            end
         end
         RS1: begin
            if (m_ready) begin
               m_valid_next = 1'b0;
               rs_done      = 1'b1;
               state_next   = IDLE;
            end
         end
         default: begin
            m_valid_next = 1'b0;
            state_next   = IDLE;
         end
      endcase
   end

   // State, holding register and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         hold_reg    <= 64'd0;
         m_data_reg  <= 32'd0;
         m_valid_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         hold_reg    <= hold_next;
         m_data_reg  <= m_data_next;
         m_valid_reg <= m_valid_next;
      end
   end

   // Transmitted-dword counter, resync dwords included; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_reg <= '0;
      end else if (handshake) begin
         stat_reg <= stat_reg + STAT_W'(1);
      end
   end

`ifdef COM_TX_RESYNC_EN
   localparam int IDLE_W = $clog2(IDLE_RESYNC_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(IDLE_RESYNC_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_MAX_M1 = IDLE_W'(IDLE_RESYNC_CYCLES - 1);
   localparam logic PENDING_RST = 1'b1;

   logic [IDLE_W-1:0] idle_cnt_reg;
   logic              idle_step;
   logic              idle_hit;
   logic              req_set;

   // Counter saturates at the threshold, so the crossing fires exactly once
   // per idle stretch; only a data accept re-arms it.
   assign idle_step = (state_reg == IDLE) & ~s_valid & (idle_cnt_reg != IDLE_MAX);
   assign idle_hit  = idle_step & (idle_cnt_reg == IDLE_MAX_M1);
   // Requests seen while a pair is already going out merge into that pair.
   assign req_set   = resync_req & (state_reg != RS0) & (state_reg != RS1);

   always_comb begin
      resync_pending_next = (resync_pending_reg & ~rs_done) | req_set | idle_hit;
   end

   // Idle-cycle counter driving the automatic resync.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_reg <= '0;
      end else if (accept) begin
         idle_cnt_reg <= '0;
      end else if (idle_step) begin
         idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
      end
   end
`else
   localparam logic PENDING_RST = 1'b0;
   logic unused_resync_req;
   logic unused_rs_done;

   assign unused_resync_req = resync_req;
   assign unused_rs_done    = rs_done;

   always_comb begin
      resync_pending_next = 1'b0;
   end
`endif

   // Resync-owed flag; with the feature on it is set out of reset so a pair
   // precedes any data.
   always_ff @(posedge clk) begin
      if (rst) begin
         resync_pending_reg <= PENDING_RST;
      end else begin
         resync_pending_reg <= resync_pending_next;
      end
   end

endmodule

// File: tb/tb_pcileech_com_tx_serializer.sv
// Self-checking bench for pcileech_com_tx_serializer. Builds the expected
// dword stream from the words it sends (hi then lo, plus marker pairs where
// the resync feature demands them) and compares it to the observed stream.
module tb_pcileech_com_tx_serializer;
   import pcileech_com_pkg::*;

   localparam int THR = 16;
`ifdef COM_TX_RESYNC_EN
   localparam bit RS_EN = 1'b1;
`else
   localparam bit RS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        resync_req;
   logic        busy;
   logic [31:0] stat_dwords;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int total_dw = 0;
   bit rdy_random = 1'b0;
   bit stall_prev = 1'b0;
   logic [31:0] prev_data = '0;
   logic [31:0] obs_q[$];
   logic [31:0] exp_q[$];
   int acc_cyc[$];

   pcileech_com_tx_serializer #(
      .IDLE_RESYNC_CYCLES(THR),
      .STAT_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .resync_req(resync_req),
      .busy(busy),
      .stat_dwords(stat_dwords)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: log every handshaken dword and enforce stall stability.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (stall_prev) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, prev_data);
         end
         if (m_valid && m_ready) obs_q.push_back(m_data);
         stall_prev = m_valid & ~m_ready;
         prev_data  = m_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Random backpressure, applied after the edge when enabled.
   always @(posedge clk) begin
      #2;
      if (rdy_random) m_ready = 1'($urandom_range(0, 1));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_word(input logic [63:0] w);
      exp_q.push_back(w[63:32]);
      exp_q.push_back(w[31:0]);
      total_dw += 2;
   endtask

   task automatic exp_pair();
      if (RS_EN) begin
         exp_q.push_back(COM_RESYNC_DWORD);
         exp_q.push_back(COM_RESYNC_DWORD);
         total_dw += 2;
      end
   endtask

   function automatic logic [63:0] rand_word();
      logic [63:0] w;
      do w = {$urandom, $urandom};
      while (w[63:32] == COM_RESYNC_DWORD || w[31:0] == COM_RESYNC_DWORD);
      return w;
   endfunction

   // Offer a word and wait (bounded) for it to be accepted.
   task automatic send(input logic [63:0] w, input bit keep_valid);
      int n = 0;
      s_data  = w;
      s_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         n++;
         if (n > 200) begin
            check("accept_timeout", 0, 1);
            s_valid = 1'b0;
            return;
         end
      end
      acc_cyc.push_back(cyc);
      tick();
      if (!keep_valid) s_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      rdy_random = 1'b0;
      tick();
      m_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!m_valid && !busy) break;
         n++;
         if (n > 200) begin
            check("drain_timeout", 0, 1);
            break;
         end
      end
      tick();
   endtask

   task automatic compare_log(input string tag);
      int n;
      check({tag, "_len"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_dw"}, obs_q[i], exp_q[i]);
      check({tag, "_stat"}, stat_dwords, total_dw);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] wa, wb;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; resync_req = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_stat", stat_dwords, 0);

      // Release with downstream stalled: a marker pair blocks upstream first.
      tick();
      rst = 1'b0;
      exp_pair();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_s_ready", s_ready, !RS_EN);
      end
      check("post_rst_m_valid", m_valid, RS_EN);
      check("post_rst_busy", busy, RS_EN);

      // Directed word with exact dword timing.
      tick();
      m_ready = 1'b1;
      send(64'h11112222_33334444, 1'b0);
      exp_word(64'h11112222_33334444);
      @(negedge clk);
      check("dir_hi_valid", m_valid, 1);
      check("dir_hi", m_data, 32'h11112222);
      @(negedge clk);
      check("dir_lo", m_data, 32'h33334444);
      @(negedge clk);
      check("dir_end_valid", m_valid, 0);
      drain();
      compare_log("directed");

      // Back-to-back: one accept every second cycle.
      acc_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         wa = rand_word();
         exp_word(wa);
         send(wa, i != 7);
      end
      for (int i = 1; i < acc_cyc.size(); i++)
         check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 2);
      drain();
      compare_log("b2b");

      // Random stalls and short gaps over 1000 words.
      rdy_random = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         int gap = $urandom_range(0, 3);
         wa = rand_word();
         exp_word(wa);
         send(wa, gap == 0);
         repeat (gap > 0 ? gap - 1 : 0) tick();
      end
      drain();
      compare_log("random");

      // resync_req while the first dword is stalled.
      m_ready = 1'b0;
      wa = rand_word();
      wb = rand_word();
      send(wa, 1'b0);
      resync_req = 1'b1;
      tick();
      resync_req = 1'b0;
      tick();
      m_ready = 1'b1;
      exp_word(wa);
      exp_pair();
      exp_word(wb);
      send(wb, 1'b0);
      drain();
      compare_log("req_in_hi");

      // Long idle: exactly one automatic pair.
      wa = rand_word();
      send(wa, 1'b0);
      exp_word(wa);
      repeat (100) tick();
      exp_pair();
      drain();
      compare_log("idle");

      // Reset mid-word: nothing reissued, marker pair precedes new data.
      m_ready = 1'b0;
      wa = rand_word();
      send(wa, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midrst_m_valid", m_valid, 0);
      check("midrst_stat", stat_dwords, 0);
      tick();
      rst = 1'b0;
      obs_q.delete();
      exp_q.delete();
      total_dw = 0;
      exp_pair();
      m_ready = 1'b1;
      wb = rand_word();
      exp_word(wb);
      send(wb, 1'b0);
      drain();
      compare_log("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
